// File: rtl/registro_bidireccional_pkg.sv
// Shared constants for the bidirectional shift register: direction encodings and default width.
package registro_pkg;
    localparam logic DIR_DER       = 1'b0;  // shift toward LSB, InMSB enters the top stage
    localparam logic DIR_IZQ       = 1'b1;  // shift toward MSB, InLSB enters the bottom stage
    localparam int   REG_WIDTH_DEF = 4;
endpackage

// File: rtl/registro_bidireccional_celda.sv
// One register stage: flop fed by its MSB-side or LSB-side neighbour (or D with REGISTRO_BIDIRECCIONAL_PLOAD_EN).
// Latency one edge; no flow control, shifts every edge.
module celda_bidireccional
    import registro_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic direccion,
    input  logic vecino_msb,
    input  logic vecino_lsb,
`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
    input  logic carga,
    input  logic d,
`endif
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
        end else if (carga) begin
            q <= d;
`endif
        end else if (direccion == DIR_DER) begin
            q <= vecino_msb;
        end else begin
            q <= vecino_lsb;
        end
    end

endmodule

// File: rtl/registro_bidireccional.sv
// WIDTH-stage bidirectional shift register; optional parallel load/readout under REGISTRO_BIDIRECCIONAL_PLOAD_EN.
// Serial latency WIDTH edges end to end; no backpressure, outputs come straight from the stage flops.
module registro_bidireccional
    import registro_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Direccion,
    input  logic             InMSB,
    input  logic             InLSB,
`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
    input  logic             Carga,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
`endif
    output logic             QMSB,
    output logic             QLSB
);

    logic [WIDTH-1:0] q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_celda
        logic vecino_msb;
        logic vecino_lsb;

        // End stages take the serial inputs; interior stages take their neighbours.
        if (i == WIDTH - 1) begin : g_top
            assign vecino_msb = InMSB;
        end else begin : g_mid_top
            assign vecino_msb = q[i+1];
        end

        if (i == 0) begin : g_bot
            assign vecino_lsb = InLSB;
        end else begin : g_mid_bot
            assign vecino_lsb = q[i-1];
        end

        celda_bidireccional u_celda (
            .clk        (clk),
            .rst        (rst),
            .direccion  (Direccion),
            .vecino_msb (vecino_msb),
            .vecino_lsb (vecino_lsb),
`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
            .carga      (Carga),
            .d          (D[i]),
`endif
            .q          (q[i])
        );
    end

    assign QMSB = q[WIDTH-1];
    assign QLSB = q[0];
`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
    assign Q    = q;
`endif

endmodule

// File: tb/tb_registro_bidireccional.sv
// Directed bench for registro_bidireccional at WIDTH=4, expected values worked out by hand.
module tb_registro_bidireccional;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    logic Direccion;
    logic InMSB;
    logic InLSB;
    logic QMSB;
    logic QLSB;
`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
    logic         Carga;
    logic [W-1:0] D;
    logic [W-1:0] Q;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    registro_bidireccional #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Direccion (Direccion),
        .InMSB     (InMSB),
        .InLSB     (InLSB),
`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
        .Carga     (Carga),
        .D         (D),
        .Q         (Q),
`endif
        .QMSB      (QMSB),
        .QLSB      (QLSB)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, clock one edge, then settle past the edge before sampling.
    task automatic step(input logic r, input logic dir, input logic msb, input logic lsb);
        rst       = r;
        Direccion = dir;
        InMSB     = msb;
        InLSB     = lsb;
        @(posedge clk);
        #1;
    endtask

    task automatic check_q(input string tag, input logic [W-1:0] exp);
        check({tag, ".q"}, 64'(dut.q), 64'(exp));
        check({tag, ".QMSB"}, 64'(QMSB), 64'(exp[W-1]));
        check({tag, ".QLSB"}, 64'(QLSB), 64'(exp[0]));
    endtask

    initial begin
        rst = 1'b1; Direccion = 1'b0; InMSB = 1'b0; InLSB = 1'b0;
`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
        Carga = 1'b0; D = '0;
`endif
        @(negedge clk);

        // Reset with random serial inputs
        step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        check_q("rst_e1", 4'b0000);
        step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        check_q("rst_e2", 4'b0000);

        // Right shift of a single 1; InLSB driven high must be ignored
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_q("der_e1", 4'b1000);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_q("der_e2", 4'b0100);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_q("der_e3", 4'b0010);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_q("der_e4", 4'b0001);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_q("der_e5", 4'b0000);

        // Left shift with InLSB held high; InMSB low must be ignored
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_q("izq_e1", 4'b0001);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_q("izq_e2", 4'b0011);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_q("izq_e3", 4'b0111);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_q("izq_e4", 4'b1111);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_q("izq_e5", 4'b1111);

        // Reversal from 1000: the MSB is shifted out
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_q("rev1_load", 4'b1000);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_q("rev1_izq", 4'b0000);

        // Reversal from 0100: bit moves up into the MSB
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_q("rev2_load", 4'b0100);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_q("rev2_izq", 4'b1000);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_q("rev2_back", 4'b0100);

        // Mid-stream reset from 1011
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_q("mid_load", 4'b1011);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check_q("mid_rst", 4'b0000);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_q("mid_after", 4'b1000);

`ifdef REGISTRO_BIDIRECCIONAL_PLOAD_EN
        // Parallel load, then right shift of the loaded word
        Carga = 1'b1; D = 4'b1010;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("pl_Q", 64'(Q), 64'(4'b1010));
        check_q("pl_load", 4'b1010);
        Carga = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("pl_shift_Q", 64'(Q), 64'(4'b0101));
        // Reset wins over load
        Carga = 1'b1; D = 4'b1111;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pl_rst_prio", 64'(Q), 64'(4'b0000));
        Carga = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/registro_bidireccional.md
REGISTRO_BIDIRECCIONAL -- requirements
Module: registro_bidireccional

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high, with ports named clk and rst.
REQ-002 Parameter WIDTH, default 4, SHALL set the number of register stages (legal range 1..64).
REQ-003 Port clk, input, 1 bit: SHALL be the rising-edge clock.
REQ-004 Port rst, input, 1 bit: SHALL be the synchronous active-high reset.
REQ-005 Port Direccion, input, 1 bit: SHALL select the shift direction (0 = toward LSB, 1 = toward MSB).
REQ-006 Port InMSB, input, 1 bit: SHALL be the serial input entering the MSB stage when Direccion=0.
REQ-007 Port InLSB, input, 1 bit: SHALL be the serial input entering the LSB stage when Direccion=1.
REQ-008 Port QMSB, output, 1 bit: SHALL equal stage WIDTH-1.
REQ-009 Port QLSB, output, 1 bit: SHALL equal stage 0.

Function
REQ-010 The internal register q[WIDTH-1:0] SHALL update only on the rising edge of clk.
REQ-011 With Direccion=0, each edge SHALL perform q <= {InMSB, q[WIDTH-1:1]}.
REQ-012 With Direccion=1, each edge SHALL perform q <= {q[WIDTH-2:0], InLSB}.
REQ-013 The unused serial input SHALL be ignored in each direction.
REQ-014 QMSB and QLSB SHALL be driven directly from flops, with no combinational path from inputs.
REQ-015 Latency: a bit entering one end SHALL appear at the far output exactly WIDTH edges later if Direccion is held constant.
REQ-016 A change of Direccion SHALL take effect on the next edge, and no stored bits other than the one shifted out SHALL be lost.
REQ-017 When WIDTH=1, the register SHALL load InMSB (Direccion=0) or InLSB (Direccion=1), and QMSB SHALL equal QLSB.

Reset
REQ-018 When rst=1 at a rising edge, q SHALL become all zeros, so QMSB=0 and QLSB=0.
REQ-019 Reset SHALL have priority over shifting and over parallel load.
REQ-020 Outputs before the first reset edge are undefined.
REQ-021 Reset asserted mid-stream SHALL discard all contents on that edge.

Configuration
REQ-022 Macro REGISTRO_BIDIRECCIONAL_PLOAD_EN SHALL, when defined, add the following ports: Carga (input, 1 bit), D (input, WIDTH bits), and Q (output, WIDTH bits, equal to q).
REQ-023 With that macro defined, Carga=1 at an edge (and rst=0) SHALL load q <= D, taking priority over shifting.
REQ-024 Without that macro, those ports and that logic SHALL be absent, and behaviour SHALL be exactly REQ-010..REQ-021.

Structure
REQ-025 Shared package registro_pkg SHALL hold the direction constants DIR_DER=1'b0 and DIR_IZQ=1'b1 and the default width constant REG_WIDTH_DEF=4.
REQ-026 One sub-module, celda_bidireccional, SHALL implement a single stage; it SHALL be a flop with a 2:1 (3:1 with load) input mux selecting the left neighbour, the right neighbour or D.
REQ-027 The top level SHALL instantiate WIDTH cells via generate, wiring the end cells to InMSB and InLSB.

Verification (WIDTH=4)
REQ-028 Reset: rst=1 for 2 edges with random inputs -> QMSB=0 and QLSB=0 after the first edge.
REQ-029 Right shift: rst=0, Direccion=0, InMSB=1 for 1 edge then 0 -> QMSB=1 after edge 1 only; QLSB=1 after edge 4 only; q=0000 after edge 5.
REQ-030 Left shift: Direccion=1, InLSB held at 1 -> QLSB=1 after edge 1; QMSB=1 after edge 4; q=1111 thereafter.
REQ-031 Direction reversal: load 1000 via right shift, then Direccion=1 with InLSB=0 for 1 edge -> q=0000 with QMSB=0; repeat with q=0100, giving q=1000 and QMSB=1.
REQ-032 Mid-operation reset: q=1011, rst=1 for one edge with InMSB=1 -> q=0000; the next shift right gives q=1000.
REQ-033 With REGISTRO_BIDIRECCIONAL_PLOAD_EN defined: Carga=1 with D=1010 -> Q=1010, QMSB=1 and QLSB=0; then Direccion=0 with InMSB=0 -> Q=0101.
